// File: rtl/alu_share_arbiter_pkg.sv
// Shared RISC-V ALU types: the existing operation encoding plus a packed request
// bundle intended for future packed requester ports.
package alu_share_arbiter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] src_a;
        logic [XLEN-1:0] src_b;
        alu_op_e         op;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Existing combinational ALU. Shifts use src_b[4:0]; SLT is signed, SLTU unsigned;
// encodings outside alu_op_e produce zero.
module alu
    import alu_share_arbiter_pkg::*;
(
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    assign shamt = src_b[4:0];

    // Pure datapath decode of the operation.
    always_comb begin
        // NOTE: every path assigns result; the default stops a latch from being inferred.
        result = '0;
        case (op)
            ALU_ADD:  result = src_a + src_b;
            ALU_SUB:  result = src_a - src_b;
            ALU_SLL:  result = src_a << shamt;
            ALU_SLT:  result = {31'd0, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: result = {31'd0, src_a < src_b};
            ALU_XOR:  result = src_a ^ src_b;
            ALU_SRL:  result = src_a >> shamt;
            ALU_SRA:  result = $unsigned($signed(src_a) >>> shamt);
            ALU_OR:   result = src_a | src_b;
            ALU_AND:  result = src_a & src_b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rr_arbiter: NUM_REQ-wide request vector in, one-hot grant (and its index) out.
// With ALU_ARB_RR_EN defined the search starts at a rotating pointer that moves past
// the winner whenever `advance` is high; otherwise it is a lowest-index-first
// priority encoder and no pointer state exists.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

`ifdef ALU_ARB_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    function automatic logic [ID_W-1:0] wrap_idx(input int base, input int ofs);
        return ID_W'((base + ofs) % NUM_REQ);
    endfunction

    // Rotating search: the first requester at or after the pointer wins.
    always_comb begin
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[wrap_idx(int'(ptr_q), k)]) begin
                found     = 1'b1;
                grant_idx = wrap_idx(int'(ptr_q), k);
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end

    // Pointer moves one past the winner only when the grant is actually taken.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    logic unused_fixed_prio;
    assign unused_fixed_prio = ^{clk, rst, advance};

    // Fixed priority: lowest asserted index wins.
    always_comb begin
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[k]) begin
                found     = 1'b1;
                grant_idx = ID_W'(k);
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between NUM_REQ requesters and
// registers {result, requester id} into a single response slot.
// Build option: define ALU_ARB_RR_EN for round-robin, default is fixed priority.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic    [NUM_REQ-1:0]         req_valid,
    output logic    [NUM_REQ-1:0]         req_ready,
    input  logic    [NUM_REQ-1:0][XLEN-1:0] req_src_a,
    input  logic    [NUM_REQ-1:0][XLEN-1:0] req_src_b,
    input  alu_op_e [NUM_REQ-1:0]         req_op,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic    [ID_W-1:0]            rsp_id,
    output logic    [XLEN-1:0]            rsp_result,
    output logic                          busy
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               slot_free;
    logic               accept;
    logic [XLEN-1:0]    alu_result;

    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_result_q, rsp_result_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Winner's operands go straight through the single ALU instance.
    alu u_alu (
        .src_a  (req_src_a[grant_idx]),
        .src_b  (req_src_b[grant_idx]),
        .op     (req_op[grant_idx]),
        .result (alu_result)
    );

    // A grant is only offered when the slot is empty or draining this cycle.
    always_comb begin
        slot_free = !rsp_valid_q || rsp_ready;
        req_ready = (rst || !slot_free) ? '0 : grant;
        accept    = |req_ready;
    end

    // Response slot: load on accept, empty on drain, otherwise hold.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant_idx;
            rsp_result_d = alu_result;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // Response register; reset clears the held payload as well as the valid flag.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign busy       = rsp_valid_q && !rsp_ready;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed + constrained-random bench for alu_share_arbiter (NUM_REQ = 2).
// Expectations follow ALU_ARB_RR_EN when it is defined for the build.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int N    = 2;
    localparam int ID_W = 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic    [N-1:0]         req_valid;
    logic    [N-1:0]         req_ready;
    logic    [N-1:0][31:0]   req_src_a;
    logic    [N-1:0][31:0]   req_src_b;
    alu_op_e [N-1:0]         req_op;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic    [ID_W-1:0]      rsp_id;
    logic    [31:0]          rsp_result;
    logic                    busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src_a  (req_src_a),
        .req_src_b  (req_src_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gold(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $unsigned($signed(a) >>> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic set_req(input int i, input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        req_op[i]    = op;
        req_src_a[i] = a;
        req_src_b[i] = b;
    endtask

    initial begin
        logic [N-1:0]  pend;
        logic [N-1:0]  exp_ready;
        int            wait_cnt [N];
        logic          m_valid;
        int            m_id;
        logic [31:0]   m_res;
        int            m_ptr;
        int            g;
        logic          rr_mode;

`ifdef ALU_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif

        // 1. reset held three cycles with both requesters valid
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        set_req(1, ALU_OR,  32'h1, 32'h2);
        #1;
        check("rst_ready_t0", req_ready, 2'b00);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_ready", req_ready, 2'b00);
            check("rst_rsp_valid", rsp_valid, 1'b0);
        end
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_result", rsp_result, 0);
        rst = 1'b0;
        #1;
        check("first_grant", req_ready, 2'b01);
        tick();
        check("first_rsp_valid", rsp_valid, 1'b1);
        check("first_rsp_id", rsp_id, 0);
        check("first_rsp_result", rsp_result, 32'd12);

        // 2. requester 0 alone: ADD 5+7
        req_valid = 2'b01;
        #1;
        check("req0_only_ready", req_ready, 2'b01);
        tick();
        check("req0_only_valid", rsp_valid, 1'b1);
        check("req0_only_id", rsp_id, 0);
        check("req0_only_result", rsp_result, 32'd12);

        // requester 1 alone (puts the round-robin pointer back on 0)
        req_valid = 2'b10;
        set_req(1, ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
        #1;
        check("req1_only_ready", req_ready, 2'b10);
        tick();
        check("req1_only_id", rsp_id, 1);
        check("req1_only_result", rsp_result, 32'h0000_FF00);

        // 3. both valid for four cycles
        req_valid = 2'b11;
        set_req(0, ALU_SUB, 32'd10, 32'd3);
        set_req(1, ALU_SRA, 32'h8000_0000, 32'd4);
        for (int c = 0; c < 4; c++) begin
            int w;
            w = (rr_mode && (c % 2 == 1)) ? 1 : 0;
            #1;
            check("both_ready", req_ready, (w == 1) ? 2'b10 : 2'b01);
            tick();
            check("both_id", rsp_id, w);
            check("both_result", rsp_result, (w == 1) ? 32'hF800_0000 : 32'd7);
        end

        // 4. backpressure for three cycles, then drain and accept together
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        set_req(0, ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_ready", req_ready, 2'b00);
            check("bp_busy", busy, 1'b1);
            tick();
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_held", rsp_result, rr_mode ? 32'hF800_0000 : 32'd7);
        end
        rsp_ready = 1'b1;
        #1;
        check("drain_accept_ready", req_ready, 2'b01);
        check("drain_accept_busy", busy, 1'b0);
        tick();
        check("drain_accept_valid", rsp_valid, 1'b1);
        check("drain_accept_id", rsp_id, 0);
        check("drain_accept_result", rsp_result, 32'h0F00_0F00);

        // 5. reset while a response is stalled
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        rst       = 1'b1;
        #1;
        check("midrst_ready", req_ready, 2'b00);
        tick();
        check("midrst_valid", rsp_valid, 1'b0);
        check("midrst_id", rsp_id, 0);
        check("midrst_result", rsp_result, 0);
        rst       = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        tick();
        check("post_rst_no_stale", rsp_valid, 1'b0);
        req_valid = 2'b11;
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        set_req(1, ALU_SUB, 32'd9, 32'd4);
        #1;
        check("post_rst_ptr", req_ready, 2'b01);
        tick();
        check("post_rst_id", rsp_id, 0);
        check("post_rst_result", rsp_result, 32'd3);

        // 6. random traffic against a reference model
        m_valid = 1'b1;
        m_ptr   = 1;
        pend    = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i] = 1'b1;
                    wait_cnt[i] = 0;
                    set_req(i, alu_op_e'(4'($urandom_range(0, 15))), $urandom(),
                            ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom());
                end
            end
            req_valid = pend;
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (!m_valid || rsp_ready) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = rr_mode ? (m_ptr + k) % N : k;
                    if (g < 0 && pend[idx]) g = idx;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("rnd_ready", req_ready, exp_ready);
            check("rnd_onehot0", $onehot0(req_ready), 1'b1);
            check("rnd_busy", busy, m_valid && !rsp_ready);
            if (g >= 0) begin
                m_valid = 1'b1;
                m_id    = g;
                m_res   = gold(req_op[g], req_src_a[g], req_src_b[g]);
                pend[g] = 1'b0;
                m_ptr   = (g + 1) % N;
                for (int i = 0; i < N; i++) begin
                    if (i != g && pend[i]) begin
                        wait_cnt[i]++;
                        if (rr_mode) check("rnd_starve", wait_cnt[i] <= N - 1, 1'b1);
                    end
                end
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
            tick();
            check("rnd_rsp_valid", rsp_valid, m_valid);
            if (m_valid) begin
                check("rnd_rsp_id", rsp_id, m_id);
                check("rnd_rsp_result", rsp_result, m_res);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
